pixel_array: RTL and testbench
==============================

// Module: pixel_array
// PURPOSE
// - Behavioural 2x2 image-sensor array (pixels 11,12 = row 1; 21,22 = row 2) with a per-pixel single-slope ADC.
// - Exposure integrates light into a per-pixel "voltage"; conversion compares a shared ramp and latches the
//   external digital ramp count from the bus; readout drives stored codes onto two shared tristate buses.
// - Sits between the sensor controller (erase/expose/convert/read sequencing, DAC/ADC ramp) and the readout logic.
// PARAMETERS
// - DV_11      64    integration increment per anaBias1 pulse, pixel 11
// - DV_12      128   same, pixel 12
// - DV_21      192   same, pixel 21
// - DV_22      255   same, pixel 22
// - RAMP_STEP  256   ramp increment per anaRamp pulse (shared by all pixels)
// - VW         16    width of voltage/ramp accumulators
// PORTS
// - clk       in   1  system clock; memory capture on falling edge
// - reset     in   1  asynchronous, active-high
// - anaBias1  in   1  exposure pulse train; each rising edge = one integration step
// - anaRamp   in   1  conversion pulse train; each rising edge = one ramp step
// - anaReset  in   1  active-low analog reset; low acts exactly as erase
// - erase     in   1  level; clears pixel voltage and ramp
// - expose    in   1  exposure phase flag (informational; integration is gated by anaBias1 pulses)
// - read1     in   1  drive row 1: pixData1=mem11, pixData2=mem12
// - read2     in   1  drive row 2: pixData1=mem21, pixData2=mem22
// - pixData1  inout 8 column-1 tristate bus (input ramp code during convert, output during read)
// - pixData2  inout 8 column-2 tristate bus
// BEHAVIOUR
// - Per pixel xy: V_xy[VW-1:0], shared R[VW-1:0], mem_xy[7:0], cmp_xy = (R > V_xy) combinational.
// - clr = reset | erase | ~anaReset; while clr high: all V_xy=0, R=0 (asynchronous). reset also sets all mem_xy=0.
// - Rising anaBias1 (clr low): V_xy <= min(V_xy+DV_xy, 2^VW-1) (saturating).
// - Rising anaRamp (clr low): R <= min(R+RAMP_STEP, 2^VW-1) (saturating).
// - Falling clk: if !cmp_xy && !read1 && !read2 then mem_xy <= column bus (x1->pixData1, x2->pixData2); else hold.
//   Pixel freezes its code once the ramp exceeds its voltage; memory never captures its own output during read.
// - Result: bus = ramp pulse count at each falling edge gives mem_xy = floor(V_xy/RAMP_STEP) (capped by last count).
// - Bus drive: read1 has priority over read2; neither high -> both buses 'z'. Drive is combinational, 0-cycle latency.
// - V_xy never tripped (R saturates <= V_xy): mem holds last bus value seen.
// - reset mid-operation: immediate clear of V, R, mem; buses 'z' unless read asserted (then drive 0).
// - erase during read: buses still driven from mem (mem unaffected by erase).
// TESTING
// - reset pulse -> mem all 0; read1 -> pixData1=0,pixData2=0; no read -> both buses 'z'.
// - erase; 255 anaBias1 pulses; 255 anaRamp pulses with bus=k after k-th pulse -> read1 gives 63/127, read2 gives 191/254.
// - 100 anaBias1 pulses, DV_11=64 (V=6400), ramp as above -> mem11=25 (trip at pulse 26).
// - read1 and read2 both high -> row 1 values driven; bus changes during read do not alter mem.
// - anaReset=0 mid-exposure then 10 pulses -> V=10*DV (prior integration lost); R=0.
// - V_22 saturates at 65535 with DV_22=65535, 2 pulses -> ramp never trips; mem22 = last bus value (255 after 255 pulses).

Source files
------------

// File: rtl/pixel_array_if.sv
// Control strobes between the sensor controller and the 2x2 pixel array.
// The controller drives every signal; the array only observes them.
interface pixel_array_if;
   logic anaBias1;
   logic anaRamp;
   logic anaReset;
   logic erase;
   logic expose;
   logic read1;
   logic read2;

   modport master (
      output anaBias1, anaRamp, anaReset, erase, expose, read1, read2
   );

   modport slave (
      input anaBias1, anaRamp, anaReset, erase, expose, read1, read2
   );
endinterface

// File: rtl/pixel_array.sv
// Behavioural 2x2 image sensor: per-pixel integration, single-slope ADC against a shared ramp, tristate row readout.
// Array index order is 0=pixel 11, 1=pixel 12, 2=pixel 21, 3=pixel 22; even indices sit on column 1.
module pixel_array #(
   parameter int DV_11     = 64,
   parameter int DV_12     = 128,
   parameter int DV_21     = 192,
   parameter int DV_22     = 255,
   parameter int RAMP_STEP = 256,
   parameter int VW        = 16
) (
   input  logic         clk,
   input  logic         reset,
   pixel_array_if.slave ctl,
   inout  wire  [7:0]   pixData1,
   inout  wire  [7:0]   pixData2
);
   localparam int NPIX = 4;
   localparam logic [VW-1:0] DV [NPIX] = '{VW'(DV_11), VW'(DV_12), VW'(DV_21), VW'(DV_22)};
   localparam logic [VW-1:0] STEP = VW'(RAMP_STEP);

   function automatic logic [VW-1:0] sat_add(input logic [VW-1:0] a, input logic [VW-1:0] b);
      logic [VW:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[VW] ? {VW{1'b1}} : s[VW-1:0];
   endfunction

   logic            w_clr;
   logic [VW-1:0]   r_v [NPIX];
   logic [VW-1:0]   r_ramp;
   logic [7:0]      r_mem [NPIX];
   logic [NPIX-1:0] w_cmp;
   logic            w_rd;
   logic [7:0]      w_d1;
   logic [7:0]      w_d2;
   logic            w_unused_expose;

   // anaReset is active-low and behaves exactly like erase
   assign w_clr = reset | ctl.erase | ~ctl.anaReset;

   always_ff @(posedge ctl.anaBias1 or posedge w_clr) begin
      if (w_clr) begin
         for (int i = 0; i < NPIX; i++) r_v[i] <= '0;
      end else begin
         for (int i = 0; i < NPIX; i++) r_v[i] <= sat_add(r_v[i], DV[i]);
      end
   end

   always_ff @(posedge ctl.anaRamp or posedge w_clr) begin
      if (w_clr) r_ramp <= '0;
      else       r_ramp <= sat_add(r_ramp, STEP);
   end

   always_comb begin
      w_cmp = '0;
      for (int i = 0; i < NPIX; i++) w_cmp[i] = (r_ramp > r_v[i]);
   end

   assign w_rd = ctl.read1 | ctl.read2;

   // Capture is blocked during readout so a pixel never latches the row being driven
   always_ff @(negedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NPIX; i++) r_mem[i] <= '0;
      end else if (!w_rd) begin
         for (int i = 0; i < NPIX; i++) begin
            if (!w_cmp[i]) r_mem[i] <= (i % 2 == 0) ? pixData1 : pixData2;
         end
      end
   end

   assign w_d1 = ctl.read1 ? r_mem[0] : r_mem[2];
   assign w_d2 = ctl.read1 ? r_mem[1] : r_mem[3];

   assign pixData1 = w_rd ? w_d1 : 8'bz;
   assign pixData2 = w_rd ? w_d2 : 8'bz;

   assign w_unused_expose = ctl.expose;
endmodule

// File: tb/tb_pixel_array.sv
// Scoreboard bench for pixel_array: directed sequences plus randomized exposure/conversion runs.
module tb_pixel_array;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   pixel_array_if intf();
   wire  [7:0] pixData1;
   wire  [7:0] pixData2;
   logic       tb_en;
   logic [7:0] tb_bus;
   assign pixData1 = tb_en ? tb_bus : 8'bz;
   assign pixData2 = tb_en ? tb_bus : 8'bz;

   pixel_array dut (
      .clk      (clk),
      .reset    (reset),
      .ctl      (intf),
      .pixData1 (pixData1),
      .pixData2 (pixData2)
   );

   typedef struct {
      logic [7:0] d1;
      logic [7:0] d2;
      string      nm;
   } exp_t;

   exp_t q[$];
   int   errors = 0;
   int   checks = 0;
   logic chk_vld = 1'b0;

   // stimulus state, applied once per cycle
   logic s_reset = 1'b1, s_bias = 1'b0, s_ramp = 1'b0, s_arst_n = 1'b1, s_erase = 1'b0;
   logic s_read1 = 1'b0, s_read2 = 1'b0;
   logic [7:0] s_bus = 8'd0;

   // reference model: pixel voltages and ramp as plain integers
   const int DVM [4] = '{64, 128, 192, 255};
   int         m_v [4];
   int         m_r;
   logic [7:0] m_mem [4];
   logic       m_pb = 1'b0, m_pr = 1'b0;

   initial begin
      for (int i = 0; i < 4; i++) begin
         m_v[i] = 0;
         m_mem[i] = 8'd0;
      end
      m_r = 0;
      reset = 1'b1;
      intf.anaBias1 = 1'b0; intf.anaRamp = 1'b0; intf.anaReset = 1'b1;
      intf.erase = 1'b0; intf.expose = 1'b0; intf.read1 = 1'b0; intf.read2 = 1'b0;
      tb_en = 1'b1;
      tb_bus = 8'd0;
   end

   task automatic cycle(input bit chk, input string nm);
      exp_t e;
      @(posedge clk);
      #1;
      reset = s_reset;
      intf.anaBias1 = s_bias; intf.anaRamp = s_ramp; intf.anaReset = s_arst_n;
      intf.erase = s_erase; intf.expose = s_bias; intf.read1 = s_read1; intf.read2 = s_read2;
      tb_en = !(s_read1 || s_read2);
      tb_bus = s_bus;
      if (s_reset || s_erase || !s_arst_n) begin
         for (int i = 0; i < 4; i++) m_v[i] = 0;
         m_r = 0;
      end else begin
         if (s_bias && !m_pb)
            for (int i = 0; i < 4; i++) m_v[i] = (m_v[i] + DVM[i] > 65535) ? 65535 : m_v[i] + DVM[i];
         if (s_ramp && !m_pr) m_r = (m_r + 256 > 65535) ? 65535 : m_r + 256;
      end
      m_pb = s_bias;
      m_pr = s_ramp;
      if (s_reset) for (int i = 0; i < 4; i++) m_mem[i] = 8'd0;
      if (chk) begin
         if (s_read1)      begin e.d1 = m_mem[0]; e.d2 = m_mem[1]; end
         else if (s_read2) begin e.d1 = m_mem[2]; e.d2 = m_mem[3]; end
         else              begin e.d1 = s_bus;    e.d2 = s_bus;    end
         e.nm = nm;
         q.push_back(e);
      end
      chk_vld = chk;
      // the falling edge of this cycle: a pixel keeps digitizing while the ramp has not passed it
      if (!s_reset && !s_read1 && !s_read2)
         for (int i = 0; i < 4; i++) if (m_r <= m_v[i]) m_mem[i] = s_bus;
   endtask

   // monitor: samples the buses mid-cycle whenever a check was issued
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #3;
         if (chk_vld) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL scoreboard_underflow: output with no expectation at %0t", $time);
            end else begin
               e = q.pop_front();
               checks++;
               if (pixData1 !== e.d1) begin
                  errors++;
                  $display("FAIL %s pixData1: got %0d expected %0d", e.nm, pixData1, e.d1);
               end
               checks++;
               if (pixData2 !== e.d2) begin
                  errors++;
                  $display("FAIL %s pixData2: got %0d expected %0d", e.nm, pixData2, e.d2);
               end
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic bias(input int n);
      for (int i = 0; i < n; i++) begin
         s_bias = 1'b1; cycle(1'b0, "");
         s_bias = 1'b0; cycle(1'b0, "");
      end
   endtask

   task automatic convert(input int m);
      for (int k = 1; k <= m; k++) begin
         s_ramp = 1'b1; s_bus = (k > 255) ? 8'd255 : 8'(k); cycle(1'b0, "");
         s_ramp = 1'b0; cycle(1'b0, "");
      end
   endtask

   task automatic do_erase();
      s_erase = 1'b1; cycle(1'b0, "");
      s_erase = 1'b0; s_bus = 8'd0; cycle(1'b0, "");
   endtask

   task automatic rd(input logic r1, input logic r2, input string nm);
      s_read1 = r1; s_read2 = r2; cycle(1'b1, nm);
      s_read1 = 1'b0; s_read2 = 1'b0; cycle(1'b0, "");
   endtask

   task automatic idle_chk(input logic [7:0] v, input string nm);
      s_bus = v; cycle(1'b1, nm);
   endtask

   initial begin
      int n, m, sel;
      repeat (3) cycle(1'b0, "");
      s_reset = 1'b0;
      cycle(1'b0, "");
      rd(1'b1, 1'b0, "reset_row1");
      idle_chk(8'd0, "reset_idle");

      // full-scale exposure: 63/127 on row 1, 191/254 on row 2
      do_erase();
      bias(255);
      convert(255);
      rd(1'b1, 1'b0, "full_row1");
      rd(1'b0, 1'b1, "full_row2");
      rd(1'b1, 1'b1, "both_reads");
      convert(1);
      idle_chk(8'd0, "idle_release");
      idle_chk(8'h5A, "idle_release2");
      rd(1'b0, 1'b1, "hold_row2");

      // erase during a long read: row 1 drives the bus, row 2 must not pick it up
      s_read1 = 1'b1; cycle(1'b0, "");
      s_erase = 1'b1; cycle(1'b1, "erase_during_read");
      repeat (3) cycle(1'b0, "");
      s_read1 = 1'b0; s_read2 = 1'b1; cycle(1'b1, "no_self_capture");
      s_erase = 1'b0; s_read2 = 1'b0; s_bus = 8'd0; cycle(1'b0, "");

      do_erase();
      bias(100);
      convert(255);
      rd(1'b1, 1'b0, "mid_row1");
      rd(1'b0, 1'b1, "mid_row2");

      // analog reset mid-exposure discards earlier integration
      do_erase();
      bias(50);
      s_arst_n = 1'b0; cycle(1'b0, "");
      s_arst_n = 1'b1; cycle(1'b0, "");
      bias(10);
      convert(255);
      rd(1'b1, 1'b0, "anareset_row1");
      rd(1'b0, 1'b1, "anareset_row2");

      // pixel 22 saturates and never trips
      do_erase();
      bias(300);
      convert(255);
      rd(1'b1, 1'b0, "sat_row1");
      rd(1'b0, 1'b1, "sat_row2");

      // reset while reading forces the driven codes to zero immediately
      s_read1 = 1'b1; cycle(1'b0, "");
      s_reset = 1'b1; cycle(1'b1, "reset_during_read");
      s_reset = 1'b0; s_read1 = 1'b0; cycle(1'b0, "");
      rd(1'b0, 1'b1, "after_reset_row2");

      for (int it = 0; it < 6; it++) begin
         n = $urandom_range(0, 300);
         m = $urandom_range(1, 256);
         do_erase();
         bias(n / 2);
         if ($urandom_range(0, 1) == 1) begin
            s_arst_n = 1'b0; cycle(1'b0, "");
            s_arst_n = 1'b1; cycle(1'b0, "");
         end
         bias(n - n / 2);
         convert(m);
         for (int r = 0; r < 3; r++) begin
            sel = $urandom_range(0, 3);
            case (sel)
               0: rd(1'b1, 1'b0, "rand_row1");
               1: rd(1'b0, 1'b1, "rand_row2");
               2: rd(1'b1, 1'b1, "rand_both");
               default: idle_chk(8'($urandom_range(0, 255)), "rand_idle");
            endcase
         end
      end

      repeat (3) cycle(1'b0, "");
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d expectations left, expected 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
